drive_z_corr_ctrl: RTL and testbench

//  Per-qubit Z-correction controller for one drive-circuit bank; successor to the single-select z-corr unit.

---
 rtl/drive_ctrl_pkg.sv | 14 +
 rtl/drive_z_corr_qubit_fsm.sv | 97 +++++++++
 rtl/drive_z_corr_ctrl.sv | 76 +++++++
 tb/tb_drive_z_corr_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_ctrl_pkg.sv
// Shared types and constants for the drive-circuit bank controllers.
// Holds the per-qubit Z-correction FSM state encoding and the zero-window substitute.
package drive_ctrl_pkg;

    typedef enum logic [1:0] {
        ZC_IDLE  = 2'd0,
        ZC_ARMED = 2'd1,
        ZC_CORR  = 2'd2
    } zc_state_e;

    // A requested window of 0 is treated as this length so a correction is never skipped.
    localparam int unsigned ZC_MIN_WIN = 1;

endpackage

// File: rtl/drive_z_corr_qubit_fsm.sv
// One qubit's Z-correction sequencer: arm, wait for local readout finish, hold a timed window.
// Owns the window/counter registers and the registered NCO-facing outputs for its channel.
module drive_z_corr_qubit_fsm
    import drive_ctrl_pkg::*;
#(
    parameter int WIN_CNT_WIDTH = 8
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm_i,
    input  logic [WIN_CNT_WIDTH-1:0] win_i,
    input  logic                     glb_fin_i,
    input  logic                     local_fin_i,
    output logic                     busy_o,
    output logic                     mode_o,
    output logic                     done_o,
    output logic                     phase_wr_en_o,
    output logic                     z_corr_wr_en_o
);

    localparam logic [WIN_CNT_WIDTH-1:0] MinWin = WIN_CNT_WIDTH'(ZC_MIN_WIN);
    localparam logic [WIN_CNT_WIDTH-1:0] LastCnt = WIN_CNT_WIDTH'(1);

    zc_state_e                state_q;
    zc_state_e                state_d;
    logic [WIN_CNT_WIDTH-1:0] win_q;
    logic [WIN_CNT_WIDTH-1:0] win_d;
    logic [WIN_CNT_WIDTH-1:0] cnt_q;
    logic [WIN_CNT_WIDTH-1:0] cnt_d;
    logic                     done_q;
    logic                     done_d;
    logic                     phase_wr_en_q;
    logic                     z_corr_wr_en_q;

    // Bank-wide finish outranks the local finish, which outranks the window countdown.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ZC_IDLE: begin
                if (arm_i) begin
                    state_d = ZC_ARMED;
                    win_d   = (win_i == '0) ? MinWin : win_i;
                end
            end
            ZC_ARMED: begin
                if (glb_fin_i) begin
                    state_d = ZC_IDLE;
                end else if (local_fin_i) begin
                    state_d = ZC_CORR;
                    cnt_d   = win_q;
                end
            end
            ZC_CORR: begin
                if (glb_fin_i) begin
                    state_d = ZC_IDLE;
                end else if (cnt_q == LastCnt) begin
                    state_d = ZC_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - LastCnt;
                end
            end
            default: begin
                state_d = ZC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ZC_IDLE;
            win_q          <= '0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            phase_wr_en_q  <= 1'b0;
            z_corr_wr_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
            phase_wr_en_q  <= ~glb_fin_i;
            z_corr_wr_en_q <= 1'b1;
        end
    end

    assign busy_o         = (state_q != ZC_IDLE);
    assign mode_o         = (state_q != ZC_CORR);
    assign done_o         = done_q;
    assign phase_wr_en_o  = phase_wr_en_q;
    assign z_corr_wr_en_o = z_corr_wr_en_q;

endmodule

// File: rtl/drive_z_corr_ctrl.sv
// Per-qubit Z-correction controller for one drive-circuit bank (one FSM per NCO channel).
// Define Z_CORR_ERR_EN to build the sticky arm-collision flag err_overlap; otherwise it is tied 0.
module drive_z_corr_ctrl
    import drive_ctrl_pkg::*;
#(
    parameter int NUM_QUBIT_PER_BANK        = 16,
    parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
    parameter int WIN_CNT_WIDTH             = 8
)
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_inst_table_in,
    input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] qubit_sel,
    input  logic [WIN_CNT_WIDTH-1:0]             z_corr_win,
    input  logic                                 glb_is_read_env_fin,
    input  logic [NUM_QUBIT_PER_BANK-1:0]        local_is_read_env_fin,
    output logic [NUM_QUBIT_PER_BANK-1:0]        nco_phase_wr_en,
    output logic [NUM_QUBIT_PER_BANK-1:0]        nco_z_corr_wr_en,
    output logic [NUM_QUBIT_PER_BANK-1:0]        nco_z_corr_mode,
    output logic [NUM_QUBIT_PER_BANK-1:0]        corr_done,
    output logic                                 busy,
    output logic                                 err_overlap
);

    logic [NUM_QUBIT_PER_BANK-1:0] arm_vec;
    logic [NUM_QUBIT_PER_BANK-1:0] busy_vec;

    // Out-of-range selects match no channel and therefore arm nothing.
    always_comb begin
        arm_vec = '0;
        for (int i = 0; i < NUM_QUBIT_PER_BANK; i++) begin
            if (valid_inst_table_in && (int'(qubit_sel) == i)) begin
                arm_vec[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_QUBIT_PER_BANK; g++) begin : g_qubit
        drive_z_corr_qubit_fsm #(
            .WIN_CNT_WIDTH(WIN_CNT_WIDTH)
        ) u_fsm (
            .clk           (clk),
            .rst           (rst),
            .arm_i         (arm_vec[g]),
            .win_i         (z_corr_win),
            .glb_fin_i     (glb_is_read_env_fin),
            .local_fin_i   (local_is_read_env_fin[g]),
            .busy_o        (busy_vec[g]),
            .mode_o        (nco_z_corr_mode[g]),
            .done_o        (corr_done[g]),
            .phase_wr_en_o (nco_phase_wr_en[g]),
            .z_corr_wr_en_o(nco_z_corr_wr_en[g])
        );
    end

    assign busy = |busy_vec;

`ifdef Z_CORR_ERR_EN
    logic err_overlap_q;

    // An arm landing on a channel that is already ARMED or CORR latches the flag until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overlap_q <= 1'b0;
        end else if (|(arm_vec & busy_vec)) begin
            err_overlap_q <= 1'b1;
        end
    end

    assign err_overlap = err_overlap_q;
`else
    assign err_overlap = 1'b0;
`endif

endmodule

// File: tb/tb_drive_z_corr_ctrl.sv
// Scoreboard testbench for drive_z_corr_ctrl: a per-cycle reference model queues expected outputs.
module tb_drive_z_corr_ctrl;

    localparam int NQ = 16;

    typedef struct {
        logic [NQ-1:0] mode;
        logic [NQ-1:0] done;
        logic [NQ-1:0] phase;
        logic [NQ-1:0] zwr;
        logic          busy;
        logic          err;
    } expT;

    logic          clk;
    logic          clkEn;
    logic          rst;
    logic          valid;
    logic [3:0]    qubitSel;
    logic [7:0]    zCorrWin;
    logic          glbFin;
    logic [NQ-1:0] localFin;
    logic [NQ-1:0] phaseWrEn;
    logic [NQ-1:0] zCorrWrEn;
    logic [NQ-1:0] zCorrMode;
    logic [NQ-1:0] corrDone;
    logic          busyOut;
    logic          errOverlap;

    expT expQ[$];
    int  mState[NQ];
    int  mWin[NQ];
    int  mCnt[NQ];
    logic mErr;
    int  lowCount[NQ];
    int  doneCount[NQ];
    int  assertCount;
    int  failCount;

    drive_z_corr_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .valid_inst_table_in  (valid),
        .qubit_sel            (qubitSel),
        .z_corr_win           (zCorrWin),
        .glb_is_read_env_fin  (glbFin),
        .local_is_read_env_fin(localFin),
        .nco_phase_wr_en      (phaseWrEn),
        .nco_z_corr_wr_en     (zCorrWrEn),
        .nco_z_corr_mode      (zCorrMode),
        .corr_done            (corrDone),
        .busy                 (busyOut),
        .err_overlap          (errOverlap)
    );

    always #5 if (clkEn) clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < NQ; i++) begin
            mState[i] = 0;
            mWin[i]   = 0;
            mCnt[i]   = 0;
        end
        mErr = 1'b0;
        expQ.delete();
    endtask

    task automatic clearCounts();
        for (int i = 0; i < NQ; i++) begin
            lowCount[i]  = 0;
            doneCount[i] = 0;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mode"}, 32'(zCorrMode), 32'hFFFF);
        checkOutput({tag, "_done"}, 32'(corrDone), 32'h0);
        checkOutput({tag, "_phase"}, 32'(phaseWrEn), 32'h0);
        checkOutput({tag, "_zwr"}, 32'(zCorrWrEn), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busyOut), 32'h0);
        checkOutput({tag, "_err"}, 32'(errOverlap), 32'h0);
    endtask

    task automatic compareResponse();
        expT e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkOutput("mode", 32'(zCorrMode), 32'(e.mode));
        checkOutput("done", 32'(corrDone), 32'(e.done));
        checkOutput("phase_wr_en", 32'(phaseWrEn), 32'(e.phase));
        checkOutput("z_corr_wr_en", 32'(zCorrWrEn), 32'(e.zwr));
        checkOutput("busy", 32'(busyOut), 32'(e.busy));
        checkOutput("err_overlap", 32'(errOverlap), 32'(e.err));
        for (int i = 0; i < NQ; i++) begin
            if (!zCorrMode[i]) lowCount[i]++;
            if (corrDone[i])   doneCount[i]++;
        end
    endtask

    // Drives one cycle of inputs, predicts the post-edge outputs, then compares after the edge.
    task automatic applyStimulus(input logic arm, input int sel, input int win,
                                 input logic glb, input logic [NQ-1:0] lfin);
        expT  e;
        logic coll;
        valid    = arm;
        qubitSel = 4'(sel);
        zCorrWin = 8'(win);
        glbFin   = glb;
        localFin = lfin;
        coll     = 1'b0;
        e.done   = '0;
        e.busy   = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            logic hit;
            hit = arm && (sel == i);
            if (mState[i] == 0) begin
                if (hit) begin
                    mState[i] = 1;
                    mWin[i]   = (win == 0) ? 1 : win;
                end
            end else begin
                if (hit) coll = 1'b1;
                if (glb) begin
                    mState[i] = 0;
                end else if (mState[i] == 1) begin
                    if (lfin[i]) begin
                        mState[i] = 2;
                        mCnt[i]   = mWin[i];
                    end
                end else if (mCnt[i] == 1) begin
                    mState[i] = 0;
                    e.done[i] = 1'b1;
                end else begin
                    mCnt[i] = mCnt[i] - 1;
                end
            end
            e.mode[i] = (mState[i] != 2);
            if (mState[i] != 0) e.busy = 1'b1;
        end
`ifdef Z_CORR_ERR_EN
        mErr = mErr | coll;
`endif
        e.err   = mErr;
        e.phase = glb ? '0 : '1;
        e.zwr   = '1;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        compareResponse();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 1'b0, '0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        clk         = 1'b0;
        clkEn       = 1'b1;
        rst         = 1'b1;
        valid       = 1'b0;
        qubitSel    = '0;
        zCorrWin    = '0;
        glbFin      = 1'b0;
        localFin    = '0;
        resetModel();
        clearCounts();
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b0;

        // Test 1: q3, window 4
        clearCounts();
        applyStimulus(1'b1, 3, 4, 1'b0, '0);
        applyStimulus(1'b0, 0, 0, 1'b0, 16'h0008);
        idleCycles(6);
        checkOutput("t1_q3_low_cycles", 32'(lowCount[3]), 32'd4);
        checkOutput("t1_q3_done_pulses", 32'(doneCount[3]), 32'd1);
        checkOutput("t1_q4_low_cycles", 32'(lowCount[4]), 32'd0);

        // Test 2: q5, zero window becomes 1; local finish on idle q9 is ignored
        clearCounts();
        applyStimulus(1'b1, 5, 0, 1'b0, 16'h0200);
        applyStimulus(1'b0, 0, 0, 1'b0, 16'h0020);
        idleCycles(3);
        checkOutput("t2_q5_low_cycles", 32'(lowCount[5]), 32'd1);
        checkOutput("t2_q5_done_pulses", 32'(doneCount[5]), 32'd1);
        checkOutput("t2_q9_low_cycles", 32'(lowCount[9]), 32'd0);

        // Test 3: q2 aborted by global finish right after entering CORR with cnt=10
        clearCounts();
        applyStimulus(1'b1, 2, 10, 1'b0, '0);
        applyStimulus(1'b0, 0, 0, 1'b0, 16'h0004);
        applyStimulus(1'b0, 0, 0, 1'b1, '0);
        checkOutput("t3_phase_low", 32'(phaseWrEn), 32'h0);
        checkOutput("t3_busy_dropped", 32'(busyOut), 32'h0);
        idleCycles(3);
        checkOutput("t3_q2_done_pulses", 32'(doneCount[2]), 32'd0);
        checkOutput("t3_q2_low_cycles", 32'(lowCount[2]), 32'd1);

        // Test 4: ARMED q7 with global and local finish together
        clearCounts();
        applyStimulus(1'b1, 7, 5, 1'b0, '0);
        applyStimulus(1'b0, 0, 0, 1'b1, 16'h0080);
        idleCycles(3);
        checkOutput("t4_q7_low_cycles", 32'(lowCount[7]), 32'd0);

        // Test 5: re-arm q1 during CORR keeps window 3
        clearCounts();
        applyStimulus(1'b1, 1, 3, 1'b0, '0);
        applyStimulus(1'b0, 0, 0, 1'b0, 16'h0002);
        applyStimulus(1'b1, 1, 9, 1'b0, '0);
        idleCycles(12);
        checkOutput("t5_q1_low_cycles", 32'(lowCount[1]), 32'd3);
`ifdef Z_CORR_ERR_EN
        checkOutput("t5_err_sticky", 32'(errOverlap), 32'd1);
`else
        checkOutput("t5_err_tied", 32'(errOverlap), 32'd0);
`endif

        // Maximum window length
        clearCounts();
        applyStimulus(1'b1, 0, 255, 1'b0, '0);
        applyStimulus(1'b0, 0, 0, 1'b0, 16'h0001);
        idleCycles(258);
        checkOutput("max_q0_low_cycles", 32'(lowCount[0]), 32'd255);
        checkOutput("max_q0_done_pulses", 32'(doneCount[0]), 32'd1);

        // Mixed random traffic against the model
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 5)), ($urandom_range(0, 19) == 0),
                          16'($urandom));
        end

        // Test 6: async reset mid-CORR with the clock stopped
        idleCycles(12);
        applyStimulus(1'b1, 3, 4, 1'b0, '0);
        applyStimulus(1'b0, 0, 0, 1'b0, 16'h0008);
        applyStimulus(1'b0, 0, 0, 1'b0, '0);
        clkEn = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checkResetValues("t6_async_reset");
        resetModel();
        #3;
        rst   = 1'b0;
        clkEn = 1'b1;
        clearCounts();
        applyStimulus(1'b1, 3, 4, 1'b0, '0);
        applyStimulus(1'b0, 0, 0, 1'b0, 16'h0008);
        idleCycles(6);
        checkOutput("t6_q3_low_cycles", 32'(lowCount[3]), 32'd4);
        checkOutput("t6_q3_done_pulses", 32'(doneCount[3]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
